pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: I/D cache miss sequencing, load-use/RAW stalls, branch flushes, operand forwarding.
// Define PIPE_FWD_EN to enable operand forwarding; without it RAW hazards on EX/MEM stall instead.
//
// state | meaning
// RUN   | normal flow, hazard and branch handling active
// IMISS | instruction refill: fetch held, bubbles into IF/ID, rest of pipe flows
// DMISS | data refill: whole pipe frozen, bubbles into MEM/WB
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MISS_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_access,
    input  logic              branch_taken,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              icache_hit,
    input  logic              dcache_hit,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              pipe_freeze,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              refill_done,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {RUN, IMISS, DMISS} state_t;

    localparam logic [7:0] MISS_LOAD = 8'(MISS_CYCLES - 1);

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic ex_hit_id, mem_hit_id, load_use, stall_req;
    logic dmiss_req, imiss_req, refill_last;

    assign ex_hit_id  = (ex_rd != '0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign mem_hit_id = (mem_rd != '0) && ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));
    assign load_use   = ex_memread && ex_hit_id;
    assign dmiss_req  = mem_access && !dcache_hit;
    assign imiss_req  = !icache_hit;
    assign refill_last = (state_q != RUN) && (cnt_q == 8'd0);

`ifdef PIPE_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] mrd, input logic mwe,
                                           input logic [REG_AW-1:0] wrd, input logic wwe);
        if (mwe && (mrd != '0) && (mrd == src))
            return 2'b10;
        else if (wwe && (wrd != '0) && (wrd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign stall_req = load_use;
    assign fwd_a = rst_n ? fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;
    assign fwd_b = rst_n ? fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;
`else
    // Without forwarding any in-flight producer must drain; WB is covered by write-first regfile.
    logic unused_fwd;
    assign unused_fwd = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
    assign stall_req  = load_use || (ex_regwrite && ex_hit_id) || (mem_regwrite && mem_hit_id);
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        pipe_freeze = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            case (state_q)
                DMISS: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    pipe_freeze = 1'b1;
                    memwb_flush = 1'b1;
                end
                IMISS: begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    if (branch_taken) begin
                        pc_en       = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end
                end
                default: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (stall_req) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    // Refill counter runs MISS_CYCLES-1 down to 0; the zero cycle is the last stalled one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (dmiss_req) begin
                        state_q <= DMISS;
                        cnt_q   <= MISS_LOAD;
                    end else if (imiss_req) begin
                        state_q <= IMISS;
                        cnt_q   <= MISS_LOAD;
                    end
                end
                IMISS, DMISS: begin
                    if (cnt_q == 8'd0)
                        state_q <= RUN;
                    else
                        cnt_q <= cnt_q - 8'd1;
                end
                default: state_q <= RUN;
            endcase
            if (!pc_en && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign refill_done = rst_n && refill_last;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations adapt to whether PIPE_FWD_EN is defined.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk, rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rt, ex_regwrite, ex_memread, mem_regwrite, mem_access, branch_taken;
    logic       wb_regwrite, icache_hit, dcache_hit;
    logic       pc_en, ifid_en, pipe_freeze, ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       refill_done;
    logic [3:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int exp_sc;

    pipe_hazard_ctrl #(.REG_AW(5), .MISS_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_access(mem_access),
        .branch_taken(branch_taken),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .icache_hit(icache_hit), .dcache_hit(dcache_hit),
        .pc_en(pc_en), .ifid_en(ifid_en), .pipe_freeze(pipe_freeze),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .refill_done(refill_done), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; mem_access = 0; branch_taken = 0;
        wb_rd = 0; wb_regwrite = 0; icache_hit = 1; dcache_hit = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        tick();
        tick();
        settle();
        chk("rst_pc_en", pc_en, 0);
        chk("rst_ifid_en", ifid_en, 0);
        chk("rst_flushes", {ifid_flush, idex_flush, exmem_flush, memwb_flush}, 4'b1111);
        chk("rst_freeze", pipe_freeze, 0);
        chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        chk("rst_refill_done", refill_done, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // Load-use on rs
        tick();
        rst_n = 1'b1;
        ex_memread = 1; ex_rd = 8; id_rs = 8;
        settle();
        chk("lu_pc_en", pc_en, 0);
        chk("lu_ifid_en", ifid_en, 0);
        chk("lu_idex_flush", idex_flush, 1);
        chk("lu_ifid_flush", ifid_flush, 0);
        tick();
        clr();
        settle();
        chk("lu_release_pc_en", pc_en, 1);
        chk("lu_stall_cnt", stall_cnt, 1);
        exp_sc = 1;

        // rt only counts when id_uses_rt is set
        ex_memread = 1; ex_rd = 8; id_rt = 8; id_uses_rt = 0;
        settle();
        chk("lu_rt_unused", pc_en, 1);
        tick();
        id_uses_rt = 1;
        settle();
        chk("lu_rt_used", pc_en, 0);
        tick();
        exp_sc++;
        clr();

        // Register 0 never hazards
        ex_memread = 1; ex_rd = 0; id_rs = 0;
        settle();
        chk("lu_reg0", pc_en, 1);
        tick();
        clr();

        // Branch overrides load-use
        ex_memread = 1; ex_rd = 8; id_rs = 8; branch_taken = 1;
        settle();
        chk("br_pc_en", pc_en, 1);
        chk("br_flushes", {ifid_flush, idex_flush, exmem_flush, memwb_flush}, 4'b1110);
        tick();
        clr();
        settle();
        chk("br_stall_cnt", stall_cnt, exp_sc);

        // RAW against EX and MEM producers stalls only without forwarding
        ex_regwrite = 1; ex_rd = 3; id_rs = 3;
        settle();
        chk("raw_ex_pc_en", pc_en, FWD);
        tick();
        if (!FWD) exp_sc++;
        clr();
        mem_regwrite = 1; mem_rd = 4; id_rt = 4; id_uses_rt = 1;
        settle();
        chk("raw_mem_pc_en", pc_en, FWD);
        tick();
        if (!FWD) exp_sc++;
        clr();
        wb_regwrite = 1; wb_rd = 6; id_rs = 6;
        settle();
        chk("raw_wb_pc_en", pc_en, 1);
        tick();
        clr();
        settle();
        chk("raw_stall_cnt", stall_cnt, exp_sc);

        // Forwarding priority
        ex_rs = 5; ex_rt = 5; mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1;
        settle();
        chk("fwd_a_mem", fwd_a, FWD ? 2'b10 : 2'b00);
        chk("fwd_b_mem", fwd_b, FWD ? 2'b10 : 2'b00);
        mem_regwrite = 0;
        settle();
        chk("fwd_a_wb", fwd_a, FWD ? 2'b01 : 2'b00);
        mem_regwrite = 1; mem_rd = 0;
        settle();
        chk("fwd_a_memreg0", fwd_a, FWD ? 2'b01 : 2'b00);
        wb_rd = 0;
        settle();
        chk("fwd_a_reg0", fwd_a, 2'b00);
        chk("fwd_b_reg0", fwd_b, 2'b00);
        clr();

        // D-miss: four frozen cycles, refill_done on the last
        do_reset();
        mem_access = 1; dcache_hit = 0;
        settle();
        chk("dm_detect_pc_en", pc_en, 1);
        chk("dm_detect_freeze", pipe_freeze, 0);
        tick();
        clr();
        for (int i = 0; i < 4; i++) begin
            branch_taken = (i == 1);
            settle();
            chk("dm_freeze", pipe_freeze, 1);
            chk("dm_pc_ifid", {pc_en, ifid_en}, 2'b00);
            chk("dm_flushes", {ifid_flush, idex_flush, exmem_flush, memwb_flush}, 4'b0001);
            chk("dm_refill_done", refill_done, i == 3);
            tick();
        end
        clr();
        settle();
        chk("dm_end_freeze", pipe_freeze, 0);
        chk("dm_end_refill_done", refill_done, 0);
        chk("dm_stall_cnt", stall_cnt, 4);

        // Simultaneous misses: DMISS first, then IMISS
        mem_access = 1; dcache_hit = 0; icache_hit = 0;
        settle();
        tick();
        mem_access = 0; dcache_hit = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("both_dmiss_freeze", pipe_freeze, 1);
            tick();
        end
        settle();
        chk("both_run_gap", {pc_en, pipe_freeze}, 2'b10);
        tick();
        icache_hit = 1;
        for (int i = 0; i < 4; i++) begin
            branch_taken = (i == 1);
            settle();
            chk("im_pc_en", pc_en, i == 1);
            chk("im_freeze", pipe_freeze, 0);
            chk("im_flushes", {ifid_flush, idex_flush, exmem_flush, memwb_flush},
                (i == 1) ? 4'b1110 : 4'b1000);
            chk("im_refill_done", refill_done, i == 3);
            tick();
        end
        clr();
        settle();
        chk("im_end_pc_en", pc_en, 1);
        chk("im_stall_cnt", stall_cnt, 11);

        // Reset in the second DMISS cycle aborts the refill
        do_reset();
        mem_access = 1; dcache_hit = 0;
        tick();
        clr();
        tick();
        settle();
        chk("abort_pre_freeze", pipe_freeze, 1);
        rst_n = 1'b0;
        settle();
        chk("abort_rst_refill", refill_done, 0);
        chk("abort_rst_freeze", pipe_freeze, 0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("abort_run_pc_en", pc_en, 1);
        chk("abort_stall_cnt", stall_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_pulse", {refill_done, pipe_freeze}, 2'b00);
            tick();
        end

        // stall_cnt saturation
        ex_memread = 1; ex_rd = 9; id_rs = 9;
        for (int i = 0; i < 20; i++) tick();
        clr();
        settle();
        chk("sat_stall_cnt", stall_cnt, 4'hf);
        tick();
        chk("sat_hold", stall_cnt, 4'hf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
